// File: rtl/pov_spi_tx_pkg.sv
// Shared constants and FSM encoding for the POV SPI frame transmitter.
// VEC_W_DEF matches the rbzero fixed-point width `F.
package pov_spi_tx_pkg;
    localparam int VEC_W_DEF = 24;
    localparam int NVEC      = 6;

    // Word slots in the frame; the highest index is shifted out first.
    localparam int IDX_PLAYER_X = 5;
    localparam int IDX_PLAYER_Y = 4;
    localparam int IDX_FACING_X = 3;
    localparam int IDX_FACING_Y = 2;
    localparam int IDX_VPLANE_X = 1;
    localparam int IDX_VPLANE_Y = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL,
        ST_GAP
    } tx_state_e;
endpackage

// File: rtl/pov_spi_tx_sclk_divider.sv
// Divider for the SPI clock: produces a one-cycle tick every D clk cycles.
// The restart input holds the count at zero so the phase lines up with the caller's state changes.
module pov_spi_tx_sclk_divider #(
    parameter int D = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);
    localparam int CW = $clog2(D + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (restart || cnt == CW'(D - 1))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = !restart && (cnt == CW'(D - 1));
endmodule

// File: rtl/pov_spi_tx.sv
// SPI mode-0 master that snapshots six view vectors and shifts them MSB-first to the rbzero POV slave.
// Define POV_TX_AUTORUN_EN to add i_vblank and start frames automatically when the vectors changed.
module pov_spi_tx
    import pov_spi_tx_pkg::*;
#(
    parameter int VEC_W   = VEC_W_DEF,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic             i_abort,
`ifdef POV_TX_AUTORUN_EN
    input  logic             i_vblank,
`endif
    input  logic [VEC_W-1:0] i_playerX,
    input  logic [VEC_W-1:0] i_playerY,
    input  logic [VEC_W-1:0] i_facingX,
    input  logic [VEC_W-1:0] i_facingY,
    input  logic [VEC_W-1:0] i_vplaneX,
    input  logic [VEC_W-1:0] i_vplaneY,
    output logic             o_sclk,
    output logic             o_mosi,
    output logic             o_ss_n,
    output logic             o_busy,
    output logic             o_done
);
    localparam int N  = NVEC * VEC_W;
    localparam int BW = $clog2(N + 1);

    tx_state_e state, state_n;
    logic [NVEC-1:0][VEC_W-1:0] words;
    logic [N-1:0]  frame;
    logic [N-1:0]  sreg;
    logic [BW-1:0] bit_cnt;
    logic          aborted;
    logic          start_req, accept, abort_now, restart, tick, shift_en;
    logic          sclk_n, ss_n_n, busy_n, done_n;

    assign words[IDX_PLAYER_X] = i_playerX;
    assign words[IDX_PLAYER_Y] = i_playerY;
    assign words[IDX_FACING_X] = i_facingX;
    assign words[IDX_FACING_Y] = i_facingY;
    assign words[IDX_VPLANE_X] = i_vplaneX;
    assign words[IDX_VPLANE_Y] = i_vplaneY;
    assign frame = words;

`ifdef POV_TX_AUTORUN_EN
    logic         vblank_q, dirty;
    logic [N-1:0] last_sent;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q  <= 1'b0;
            dirty     <= 1'b1;
            last_sent <= '0;
        end else begin
            vblank_q <= i_vblank;
            if (accept) begin
                dirty     <= 1'b0;
                last_sent <= frame;
            end else if (frame != last_sent) begin
                dirty <= 1'b1;
            end
        end
    end

    assign start_req = i_start || (i_vblank && !vblank_q && dirty);
`else
    assign start_req = i_start;
`endif

    assign accept    = (state == ST_IDLE) && start_req;
    assign abort_now = i_abort && (state inside {ST_LEAD, ST_SHIFT, ST_TRAIL});
    assign restart   = (state == ST_IDLE) || abort_now;

    pov_spi_tx_sclk_divider #(.D(CLK_DIV)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_n  = state;
        sclk_n   = o_sclk;
        ss_n_n   = o_ss_n;
        busy_n   = o_busy;
        done_n   = 1'b0;
        shift_en = 1'b0;
        if (abort_now) begin
            state_n = ST_GAP;
            sclk_n  = 1'b0;
            ss_n_n  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    state_n = ST_LEAD;
                    ss_n_n  = 1'b0;
                    busy_n  = 1'b1;
                end
                ST_LEAD: if (tick) begin
                    state_n = ST_SHIFT;
                    sclk_n  = 1'b1;
                end
                ST_SHIFT: if (tick) begin
                    // falling edge moves mosi on; the final shift leaves zeros behind
                    sclk_n   = !o_sclk;
                    shift_en = o_sclk;
                    if (o_sclk && bit_cnt == BW'(1))
                        state_n = ST_TRAIL;
                end
                ST_TRAIL: if (tick) begin
                    state_n = ST_GAP;
                    ss_n_n  = 1'b1;
                end
                ST_GAP: if (tick) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    done_n  = !aborted;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            o_sclk <= 1'b0;
            o_ss_n <= 1'b1;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= state_n;
            o_sclk <= sclk_n;
            o_ss_n <= ss_n_n;
            o_busy <= busy_n;
            o_done <= done_n;
        end
    end

    // o_mosi is taken straight from the top of the shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg    <= '0;
            bit_cnt <= '0;
            aborted <= 1'b0;
        end else if (accept) begin
            sreg    <= frame;
            bit_cnt <= BW'(N);
            aborted <= 1'b0;
        end else if (abort_now) begin
            sreg    <= '0;
            aborted <= 1'b1;
        end else if (shift_en) begin
            sreg    <= {sreg[N-2:0], 1'b0};
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

    assign o_mosi = sreg[N-1];
endmodule
